// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter for two requesters sharing one output channel through a 2-to-1 mux.
// Grants are held for at most MAX_BURST beats, and handoffs between requesters have no bubble.
module mux2to1_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

   localparam logic [3:0] CntLast = 4'(MAX_BURST - 1);

   state_e     state_q;
   logic       sel_q;
   logic       last_q;
   logic [3:0] cnt_q;

   logic own_idx;
   logic own_v;
   logic oth_v;
   logic xfer;
   logic exhaust;
   logic idle_pick;

   assign own_idx = (state_q == StGrant1);
   assign own_v   = own_idx ? in1_valid : in0_valid;
   assign oth_v   = own_idx ? in0_valid : in1_valid;
   assign xfer    = (state_q != StIdle) & own_v & out_ready;
   assign exhaust = xfer & (cnt_q == CntLast);

   // On a tie, the requester that was not granted last wins.
   assign idle_pick = (in0_valid & in1_valid) ? ~last_q : in1_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in0_valid | in1_valid) begin
                  state_q <= idle_pick ? StGrant1 : StGrant0;
                  sel_q   <= idle_pick;
                  last_q  <= idle_pick;
                  cnt_q   <= 4'd0;
               end
            end
            StGrant0, StGrant1: begin
               if (!own_v || exhaust) begin
                  if (oth_v) begin
                     state_q <= own_idx ? StGrant0 : StGrant1;
                     sel_q   <= ~own_idx;
                     last_q  <= ~own_idx;
                     cnt_q   <= 4'd0;
                  end else if (exhaust) begin
                     cnt_q <= 4'd0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (xfer) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in0_ready = (state_q == StGrant0) & out_ready;
   assign in1_ready = (state_q == StGrant1) & out_ready;
   assign out_valid = (state_q == StGrant0) ? in0_valid :
                      (state_q == StGrant1) ? in1_valid : 1'b0;
   assign out_data  = sel_q ? in1_data : in0_data;
   assign sel       = sel_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed bench for mux2to1_arbiter: reset, streaming, round-robin contention,
// backpressure, early release and asynchronous reset mid-burst.
module tb_mux2to1_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in0_valid, in1_valid, in0_ready, in1_ready;
   logic [7:0] in0_data, in1_data, out_data;
   logic       out_valid, out_ready, sel, busy;

   int vectors     = 0;
   int miscompares = 0;

   mux2to1_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_seq [12];
   int         a_idx, b_idx;

   initial begin
      exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                  8'hA4, 8'hA5, 8'hA6, 8'hA7};

      // Reset with both valids high.
      reset = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
      in0_data = 8'h55; in1_data = 8'h66;
      #1;
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_oval", 16'(out_valid), 16'd0);
      chk("rst_rdy0", 16'(in0_ready), 16'd0);
      chk("rst_rdy1", 16'(in1_ready), 16'd0);
      chk("rst_sel", 16'(sel), 16'd0);
      chk("rst_data", 16'(out_data), 16'h55);
      tick();
      tick();
      chk("rst_busy2", 16'(busy), 16'd0);
      reset = 1'b0;
      tick();
      // First tie goes to requester 0.
      chk("first_busy", 16'(busy), 16'd1);
      chk("first_sel", 16'(sel), 16'd0);
      chk("first_rdy0", 16'(in0_ready), 16'd1);
      chk("first_rdy1", 16'(in1_ready), 16'd0);
      chk("first_data", 16'(out_data), 16'h55);
      tick();
      in0_valid = 1'b0; in1_valid = 1'b0;
      tick();
      chk("idle_busy", 16'(busy), 16'd0);
      chk("idle_oval", 16'(out_valid), 16'd0);

      // Single requester 1 stream, re-issued grant at burst boundary.
      in1_valid = 1'b1; in1_data = 8'h10;
      #1;
      chk("s_idle", 16'(busy), 16'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         in1_data = 8'(8'h10 + i);
         #1;
         chk("s_oval", 16'(out_valid), 16'd1);
         chk("s_rdy1", 16'(in1_ready), 16'd1);
         chk("s_data", 16'(out_data), 16'(8'h10 + i));
         chk("s_sel", 16'(sel), 16'd1);
         chk("s_cnt", 16'(dut.cnt_q), 16'(i % 4));
         tick();
      end
      in1_valid = 1'b0;
      tick();
      chk("s_end_busy", 16'(busy), 16'd0);
      chk("s_end_sel", 16'(sel), 16'd1);

      // Contention: in1 was last, so in0 wins; bursts of 4 alternate.
      a_idx = 0; b_idx = 0;
      in0_valid = 1'b1; in1_valid = 1'b1;
      tick();
      for (int j = 0; j < 12; j++) begin
         in0_data = 8'(8'hA0 + a_idx);
         in1_data = 8'(8'hB0 + b_idx);
         #1;
         chk("rr_data", 16'(out_data), 16'(exp_seq[j]));
         chk("rr_sel", 16'(sel), 16'(((j / 4) % 2) == 1));
         chk("rr_oval", 16'(out_valid), 16'd1);
         if (((j / 4) % 2) == 0) a_idx++;
         else b_idx++;
         tick();
      end
      chk("rr_sel_after", 16'(sel), 16'd1);
      in0_valid = 1'b0; in1_valid = 1'b0;
      tick();
      chk("rr_idle", 16'(busy), 16'd0);

      // Backpressure mid-burst on requester 0.
      in0_valid = 1'b1; in0_data = 8'hC0;
      tick();
      chk("bp_sel", 16'(sel), 16'd0);
      tick();
      in0_data = 8'hC1;
      tick();
      in0_data = 8'hC2; out_ready = 1'b0; in1_valid = 1'b1; in1_data = 8'hD9;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_data", 16'(out_data), 16'hC2);
         chk("bp_rdy0", 16'(in0_ready), 16'd0);
         chk("bp_cnt", 16'(dut.cnt_q), 16'd2);
         chk("bp_sel_hold", 16'(sel), 16'd0);
         chk("bp_busy", 16'(busy), 16'd1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_resume_rdy", 16'(in0_ready), 16'd1);
      chk("bp_resume_data", 16'(out_data), 16'hC2);
      tick();
      in0_data = 8'hC3;
      #1;
      chk("bp_last_cnt", 16'(dut.cnt_q), 16'd3);
      tick();
      chk("bp_switch_sel", 16'(sel), 16'd1);
      chk("bp_switch_rdy1", 16'(in1_ready), 16'd1);
      chk("bp_switch_data", 16'(out_data), 16'hD9);

      // Early release to a waiting requester 1.
      in0_valid = 1'b0; in1_valid = 1'b0;
      tick();
      in0_valid = 1'b1; in0_data = 8'hE0;
      tick();
      chk("er_sel0", 16'(sel), 16'd0);
      tick();
      in0_data = 8'hE1; in1_valid = 1'b1;
      tick();
      in0_valid = 1'b0;
      tick();
      chk("er_sel1", 16'(sel), 16'd1);
      chk("er_rdy1", 16'(in1_ready), 16'd1);
      tick();
      in1_valid = 1'b0;
      tick();
      chk("er_idle", 16'(busy), 16'd0);
      chk("er_idle_sel", 16'(sel), 16'd1);

      // Asynchronous reset during beat 2 of a requester-1 grant.
      in1_valid = 1'b1; in1_data = 8'h70;
      tick();
      tick();
      in1_data = 8'h71;
      #1;
      chk("ar_pre_rdy1", 16'(in1_ready), 16'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("ar_rdy1", 16'(in1_ready), 16'd0);
      chk("ar_oval", 16'(out_valid), 16'd0);
      chk("ar_sel", 16'(sel), 16'd0);
      chk("ar_busy", 16'(busy), 16'd0);
      in0_valid = 1'b1; in0_data = 8'h80;
      tick();
      reset = 1'b0;
      tick();
      chk("ar_tie_sel", 16'(sel), 16'd0);
      chk("ar_tie_rdy0", 16'(in0_ready), 16'd1);
      chk("ar_tie_data", 16'(out_data), 16'h80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
